ex_muldiv_iter: RTL

//  Iterative radix-2 multiply/divide unit for the EX stage; generalises the single-cycle multiply to a parametrised-width

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_sign_fix.sv | 35 +++
 rtl/ex_muldiv_iter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and op-decode helpers for the iterative mul/div unit
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        RUN,
        DONE
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: operand magnitudes on entry and sign correction of the raw result on exit
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    output logic               neg_q_o,
    output logic               neg_r_o,
    input  logic               is_div_i,
    input  logic               neg_q_i,
    input  logic               neg_r_i,
    input  logic [2*WIDTH-1:0] raw_i,
    output logic [2*WIDTH-1:0] fix_o
);

    logic a_neg, b_neg;
    logic [WIDTH-1:0] rem, quo;

    // Product and quotient flip when operand signs differ; remainder follows the dividend.
    always_comb begin
        a_neg   = signed_i & a_i[WIDTH-1];
        b_neg   = signed_i & b_i[WIDTH-1];
        a_mag_o = a_neg ? -a_i : a_i;
        b_mag_o = b_neg ? -b_i : b_i;
        neg_q_o = a_neg ^ b_neg;
        neg_r_o = a_neg;
        rem     = neg_r_i ? -raw_i[2*WIDTH-1:WIDTH] : raw_i[2*WIDTH-1:WIDTH];
        quo     = neg_q_i ? -raw_i[WIDTH-1:0] : raw_i[WIDTH-1:0];
        fix_o   = is_div_i ? {rem, quo} : (neg_q_i ? -raw_i : raw_i);
    end

endmodule

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative radix-2 MULT/MULTU/DIV/DIVU engine for the EX stage
module ex_muldiv_iter
    import md_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);

    md_state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d, den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic ready_q, ready_d, dz_q, dz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic qneg_in, rneg_in, div_in;
    logic [WIDTH:0] sum, rem_sh, trial, hi_step;
    logic [WIDTH-1:0] lo_step;
    logic [2*WIDTH-1:0] fixed;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_i (md_is_signed(op_i)),
        .a_i      (opdata1_i),
        .b_i      (opdata2_i),
        .a_mag_o  (a_mag),
        .b_mag_o  (b_mag),
        .neg_q_o  (qneg_in),
        .neg_r_o  (rneg_in),
        .is_div_i (md_is_div(op_q)),
        .neg_q_i  (qneg_q),
        .neg_r_i  (rneg_q),
        .raw_i    ({hi_step[WIDTH-1:0], lo_step}),
        .fix_o    (fixed)
    );

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        sum     = hi_q + (lo_q[0] ? {1'b0, den_q} : '0);
        rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, den_q};
        hi_step = md_is_div(op_q) ? (trial[WIDTH] ? rem_sh : trial) : {1'b0, sum[WIDTH:1]};
        lo_step = md_is_div(op_q) ? {lo_q[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
    end

    // Next-state for the FSM and datapath; annul overrides everything outside IDLE.
    always_comb begin
        div_in   = md_is_div(op_i);
        state_d  = state_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = ready_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (start_i && !annul_i) begin
                op_d    = op_i;
                qneg_d  = qneg_in;
                rneg_d  = rneg_in;
                hi_d    = '0;
                lo_d    = div_in ? a_mag : b_mag;
                den_d   = div_in ? b_mag : a_mag;
                cnt_d   = '0;
                state_d = (div_in && opdata2_i == '0) ? BYZERO : RUN;
            end
            BYZERO: begin
                state_d  = DONE;
                result_d = '0;
                ready_d  = 1'b1;
                dz_d     = 1'b1;
            end
            RUN: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = fixed;
                    ready_d  = 1'b1;
                end
            end
            default: if (!start_i) begin
                state_d = IDLE;
                ready_d = 1'b0;
                dz_d    = 1'b0;
            end
        endcase
        if (annul_i && state_q != IDLE) begin
            state_d  = IDLE;
            result_d = '0;
            ready_d  = 1'b0;
            dz_d     = 1'b0;
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            dz_q     <= dz_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign div_zero_o = dz_q;
    assign busy_o     = state_q == BYZERO || state_q == RUN;

endmodule
